// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin sharing of the peripheral bus between two
// masters (M0 = CPU load/store unit, M1 = DMA/sequencer). Each transfer is a
// single-beat read or write of one 32-bit word; every bus-side and
// master-side output is registered.
module periph_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        HRESET,

    input  logic        M0_REQ,
    input  logic        M0_WRITE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_GNT,
    output logic        M0_DONE,
    output logic [31:0] M0_RDATA,

    input  logic        M1_REQ,
    input  logic        M1_WRITE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_GNT,
    output logic        M1_DONE,
    output logic [31:0] M1_RDATA,

    output logic        HWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA
);

    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    state_e        state_q;
    logic [CW-1:0] wait_q;
    logic          last_owner_q;
    logic          hwrite_q;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          any_req_d;
    logic          pick_m1_d;

    // Round-robin choice: a lone requester wins, a tie goes to the master
    // that did not own the bus last.
    always_comb begin
        any_req_d = M0_REQ | M1_REQ;
        pick_m1_d = M1_REQ & (~M0_REQ | ~last_owner_q);
    end

    // Transfer FSM; arbitration only in IDLE, outputs registered alongside state.
    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            last_owner_q <= 1'b1;
            hwrite_q     <= 1'b0;
            paddr_q      <= IDLE_ADDR;
            pwdata_q     <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                    if (any_req_d) begin
                        last_owner_q <= pick_m1_d;
                        hwrite_q     <= pick_m1_d ? M1_WRITE : M0_WRITE;
                        paddr_q      <= pick_m1_d ? M1_ADDR  : M0_ADDR;
                        pwdata_q     <= pick_m1_d ? M1_WDATA : M0_WDATA;
                        gnt_q        <= pick_m1_d ? 2'b10 : 2'b01;
                        wait_q       <= CW'(WAIT_STATES);
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == '0) begin
                        // Last ACCESS cycle: PRDATA still reflects the latched address.
                        if (!hwrite_q) begin
                            if (gnt_q[1]) rdata1_q <= PRDATA;
                            else          rdata0_q <= PRDATA;
                        end
                        hwrite_q <= 1'b0;
                        paddr_q  <= IDLE_ADDR;
                        done_q   <= gnt_q;
                        state_q  <= ST_DONE;
                    end else begin
                        wait_q <= wait_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign M0_GNT   = gnt_q[0];
    assign M1_GNT   = gnt_q[1];
    assign M0_DONE  = done_q[0];
    assign M1_DONE  = done_q[1];
    assign M0_RDATA = rdata0_q;
    assign M1_RDATA = rdata1_q;
    assign HWRITE   = hwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;

endmodule
